// File: rtl/pep_batch_issuer.sv
// PBS slot ring allocator and batch former for the pe_pbs processing pipe.
// Build option: define PEP_BATCH_TIMEOUT_EN to issue partial batches after TIMEOUT_CYC idle cycles.
module pep_batch_issuer #(
   parameter int  BATCH_NB     = 1,
   parameter int  BATCH_PBS_NB = 12,
   parameter int  TOTAL_PBS_NB = 32,
   parameter int  TIMEOUT_CYC  = 64,
   localparam int PID_W        = $clog2(TOTAL_PBS_NB),
   localparam int NB_W         = $clog2(BATCH_PBS_NB + 1),
   localparam int CNT_W        = $clog2(TOTAL_PBS_NB + 1)
) (
   input  logic             clk,
   input  logic             a_rst_n,
   input  logic             load_vld,
   output logic             load_rdy,
   output logic [PID_W-1:0] load_pid,
   input  logic             flush,
   output logic             batch_cmd_vld,
   input  logic             batch_cmd_rdy,
   output logic [PID_W-1:0] batch_cmd_pid,
   output logic [NB_W-1:0]  batch_cmd_pbs_nb,
   input  logic             batch_done,
   output logic [CNT_W-1:0] free_slot_nb,
   output logic [CNT_W-1:0] inflight_nb,
   output logic             err_done_unexp
);

   localparam int FIFO_AW    = (BATCH_NB > 1) ? $clog2(BATCH_NB) : 1;
   localparam int FIFO_DEPTH = 1 << FIFO_AW;

   if (TOTAL_PBS_NB < BATCH_PBS_NB || BATCH_NB < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("pep_batch_issuer: inconsistent parameters");
   end

   typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

   state_t             state_reg, state_next;
   logic [PID_W-1:0]   alloc_ptr_reg, issue_ptr_reg, free_ptr_reg;
   logic [CNT_W-1:0]   pend_reg, free_nb_reg, inflight_reg;
   logic [CNT_W-1:0]   pend_after_issue, pend_next, free_next, inflight_next;
   logic               flush_reg, flush_next, err_reg;
   logic [PID_W-1:0]   cmd_pid_reg;
   logic [NB_W-1:0]    cmd_nb_reg, batch_n, done_nb;
   logic [NB_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic               load_hs, issue_hs, issue_start, done_ok, timeout;

   // Ring pointers wrap at TOTAL_PBS_NB, which need not be a power of two.
   function automatic logic [PID_W-1:0] ptr_add(input logic [PID_W-1:0] ptr, input logic [NB_W-1:0] inc);
      int sum;
      sum = int'(ptr) + int'(inc);
      if (sum >= TOTAL_PBS_NB) sum = sum - TOTAL_PBS_NB;
      return PID_W'(sum);
   endfunction

   function automatic logic [FIFO_AW-1:0] fifo_inc(input logic [FIFO_AW-1:0] p);
      return (p == FIFO_AW'(BATCH_NB - 1)) ? '0 : p + FIFO_AW'(1);
   endfunction

   assign load_hs     = load_vld && (free_nb_reg != '0);
   assign issue_hs    = (state_reg == ISSUE) && batch_cmd_rdy;
   assign issue_start = (state_reg == FILL) && (state_next == ISSUE);
   assign done_ok     = batch_done && (inflight_reg != '0);
   assign done_nb     = fifo_mem[rd_ptr_reg];
   assign batch_n     = (pend_reg >= CNT_W'(BATCH_PBS_NB)) ? NB_W'(BATCH_PBS_NB) : NB_W'(pend_reg);

   assign pend_after_issue = pend_reg - (issue_hs ? CNT_W'(cmd_nb_reg) : '0);
   assign pend_next        = pend_after_issue + CNT_W'(load_hs);
   assign free_next        = free_nb_reg - CNT_W'(load_hs) + (done_ok ? CNT_W'(done_nb) : '0);
   assign inflight_next    = inflight_reg + CNT_W'(issue_hs) - CNT_W'(done_ok);

   // A flush covers what is pending when it arrives; it retires once a batch drains that backlog.
   always_comb begin
      flush_next = flush_reg || (flush && (pend_reg != '0));
      if (issue_hs && (pend_after_issue == '0)) flush_next = 1'b0;
   end

`ifdef PEP_BATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] idle_cnt_reg;

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n)                               idle_cnt_reg <= '0;
      else if (state_reg != FILL || load_hs)      idle_cnt_reg <= '0;
      else if (idle_cnt_reg != TO_W'(TIMEOUT_CYC)) idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
   end

   assign timeout = (idle_cnt_reg == TO_W'(TIMEOUT_CYC)) && (pend_reg != '0);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (pend_reg != '0) state_next = FILL;
         FILL:    if ((inflight_reg < CNT_W'(BATCH_NB)) &&
                      ((pend_reg >= CNT_W'(BATCH_PBS_NB)) || flush_reg || timeout))
                     state_next = ISSUE;
         ISSUE:   if (batch_cmd_rdy) state_next = (pend_next != '0) ? FILL : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load_rdy         = (free_nb_reg != '0);
      load_pid         = alloc_ptr_reg;
      batch_cmd_vld    = (state_reg == ISSUE);
      batch_cmd_pid    = cmd_pid_reg;
      batch_cmd_pbs_nb = cmd_nb_reg;
      free_slot_nb     = free_nb_reg;
      inflight_nb      = inflight_reg;
      err_done_unexp   = err_reg;
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         alloc_ptr_reg <= '0;
         issue_ptr_reg <= '0;
         free_ptr_reg  <= '0;
         pend_reg      <= '0;
         free_nb_reg   <= CNT_W'(TOTAL_PBS_NB);
         inflight_reg  <= '0;
         flush_reg     <= 1'b0;
         err_reg       <= 1'b0;
         cmd_pid_reg   <= '0;
         cmd_nb_reg    <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
      end else begin
         if (load_hs) alloc_ptr_reg <= ptr_add(alloc_ptr_reg, NB_W'(1));
         if (issue_hs) begin
            issue_ptr_reg <= ptr_add(issue_ptr_reg, cmd_nb_reg);
            wr_ptr_reg    <= fifo_inc(wr_ptr_reg);
         end
         if (done_ok) begin
            free_ptr_reg <= ptr_add(free_ptr_reg, done_nb);
            rd_ptr_reg   <= fifo_inc(rd_ptr_reg);
         end
         if (issue_start) begin
            cmd_pid_reg <= issue_ptr_reg;
            cmd_nb_reg  <= batch_n;
         end
         if (batch_done && (inflight_reg == '0)) err_reg <= 1'b1;
         pend_reg     <= pend_next;
         free_nb_reg  <= free_next;
         inflight_reg <= inflight_next;
         flush_reg    <= flush_next;
      end
   end

   // In-flight batch sizes; only read while a batch is outstanding, so no reset needed.
   always_ff @(posedge clk) begin
      if (issue_hs) fifo_mem[wr_ptr_reg] <= cmd_nb_reg;
   end

endmodule

// File: tb/tb_pep_batch_issuer.sv
// Directed bench for pep_batch_issuer with a transaction-level slot/batch model checked every cycle.
// Also exercises the idle-timeout path when PEP_BATCH_TIMEOUT_EN is defined.
module tb_pep_batch_issuer;

   localparam int TOTAL = 32;
   localparam int BPN   = 12;
   localparam int TOC   = 64;

   logic       clk, a_rst_n;
   logic       load_vld, flush, batch_cmd_rdy, batch_done;
   logic       load_rdy, batch_cmd_vld, err_done_unexp;
   logic [4:0] load_pid, batch_cmd_pid;
   logic [3:0] batch_cmd_pbs_nb;
   logic [5:0] free_slot_nb, inflight_nb;

   int checks = 0;
   int errors = 0;

   pep_batch_issuer #(.BATCH_NB(1), .BATCH_PBS_NB(BPN), .TOTAL_PBS_NB(TOTAL), .TIMEOUT_CYC(TOC)) dut (
      .clk(clk), .a_rst_n(a_rst_n),
      .load_vld(load_vld), .load_rdy(load_rdy), .load_pid(load_pid),
      .flush(flush),
      .batch_cmd_vld(batch_cmd_vld), .batch_cmd_rdy(batch_cmd_rdy),
      .batch_cmd_pid(batch_cmd_pid), .batch_cmd_pbs_nb(batch_cmd_pbs_nb),
      .batch_done(batch_done),
      .free_slot_nb(free_slot_nb), .inflight_nb(inflight_nb),
      .err_done_unexp(err_done_unexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: slots allocated in ring order, batches consume pending pids in order,
   // completions release the oldest batch. Updated once per cycle from observed handshakes.
   int m_alloc, m_issue, m_free, m_inflight, m_pend, m_pend_prev, m_err;
   int m_sizes[$];
   bit cmd_open;
   int exp_pid, exp_nb;

   always @(negedge clk) begin
      if (!a_rst_n) begin
         m_alloc = 0; m_issue = 0; m_free = TOTAL; m_inflight = 0;
         m_pend = 0; m_pend_prev = 0; m_err = 0; cmd_open = 0;
         m_sizes.delete();
      end else begin
         bit load_ok;
         chk("mdl_load_rdy", int'(load_rdy), int'(m_free != 0));
         chk("mdl_load_pid", int'(load_pid), m_alloc);
         chk("mdl_free_nb", int'(free_slot_nb), m_free);
         chk("mdl_inflight", int'(inflight_nb), m_inflight);
         chk("mdl_err", int'(err_done_unexp), m_err);
         if (batch_cmd_vld) begin
            if (!cmd_open) begin
               cmd_open = 1;
               exp_pid  = m_issue;
               exp_nb   = (m_pend_prev < BPN) ? m_pend_prev : BPN;
            end
            chk("mdl_cmd_pid", int'(batch_cmd_pid), exp_pid);
            chk("mdl_cmd_nb", int'(batch_cmd_pbs_nb), exp_nb);
         end
         load_ok     = load_vld && (m_free != 0);
         m_pend_prev = m_pend;
         if (batch_done) begin
            if (m_sizes.size() == 0) m_err = 1;
            else begin
               m_free = m_free + m_sizes.pop_front();
               m_inflight--;
            end
         end
         if (batch_cmd_vld && batch_cmd_rdy) begin
            m_issue = (m_issue + exp_nb) % TOTAL;
            m_pend  = m_pend - exp_nb;
            m_inflight++;
            m_sizes.push_back(exp_nb);
            cmd_open = 0;
         end
         if (load_ok) begin
            m_alloc = (m_alloc + 1) % TOTAL;
            m_pend++;
            m_free--;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_n(input int n);
      for (int i = 0; i < n; i++) begin
         load_vld = 1'b1;
         tick();
      end
      load_vld = 1'b0;
   endtask

   task automatic flush_pulse();
      flush = 1'b1; tick(); flush = 1'b0;
   endtask

   task automatic do_done();
      tick(); batch_done = 1'b1; tick(); batch_done = 1'b0;
   endtask

   task automatic wait_cmd(input string name, input int pid, input int nb);
      int k;
      k = 0;
      while (!batch_cmd_vld && k < 100) begin tick(); k++; end
      chk({name, "_vld"}, int'(batch_cmd_vld), 1);
      chk({name, "_pid"}, int'(batch_cmd_pid), pid);
      chk({name, "_nb"}, int'(batch_cmd_pbs_nb), nb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst_n = 1'b1; load_vld = 1'b0; flush = 1'b0; batch_cmd_rdy = 1'b1; batch_done = 1'b0;
      #3 a_rst_n = 1'b0;
      tick(); tick();
      // T1: reset state
      chk("t1_load_rdy", int'(load_rdy), 1);
      chk("t1_free", int'(free_slot_nb), 32);
      chk("t1_vld", int'(batch_cmd_vld), 0);
      chk("t1_inflight", int'(inflight_nb), 0);
      chk("t1_cmd_pid", int'(batch_cmd_pid), 0);
      chk("t1_cmd_nb", int'(batch_cmd_pbs_nb), 0);
      a_rst_n = 1'b1;
      tick();

      // T2: full batch, two-cycle latency after the 12th load
      load_n(12);
      chk("t2_vld_early", int'(batch_cmd_vld), 0);
      tick();
      chk("t2_vld", int'(batch_cmd_vld), 1);
      chk("t2_pid", int'(batch_cmd_pid), 0);
      chk("t2_nb", int'(batch_cmd_pbs_nb), 12);
      tick();
      chk("t2_inflight", int'(inflight_nb), 1);
      chk("t2_free", int'(free_slot_nb), 20);
      batch_done = 1'b1; tick(); batch_done = 1'b0;
      chk("t2_free_back", int'(free_slot_nb), 32);

      // T3: partial batch via flush
      load_n(5);
      repeat (5) tick();
      chk("t3_no_vld", int'(batch_cmd_vld), 0);
      flush_pulse();
      wait_cmd("t3", 12, 5);
      do_done();

      // T4: back-pressure keeps the command stable while loads continue
      batch_cmd_rdy = 1'b0;
      load_n(12);
      wait_cmd("t4", 17, 12);
      for (int i = 0; i < 12; i++) begin
         load_vld = 1'b1;
         tick();
         chk("t4_hold_pid", int'(batch_cmd_pid), 17);
         chk("t4_hold_nb", int'(batch_cmd_pbs_nb), 12);
         chk("t4_hold_inflight", int'(inflight_nb), 0);
      end
      load_vld = 1'b0;
      batch_cmd_rdy = 1'b1;
      tick();
      chk("t4_inflight", int'(inflight_nb), 1);
      repeat (3) begin
         tick();
         chk("t4_blocked_vld", int'(batch_cmd_vld), 0);
      end
      chk("t4_free", int'(free_slot_nb), 8);
      do_done();
      wait_cmd("t4b", 29, 12);
      do_done();

      // T5: batch spanning the ring wrap
      load_n(21);
      chk("t5_inflight", int'(inflight_nb), 1);
      do_done();
      flush_pulse();
      wait_cmd("t5a", 21, 9);
      do_done();
      load_n(4);
      flush_pulse();
      wait_cmd("t5", 30, 4);
      chk("t5_load_pid", int'(load_pid), 2);
      do_done();

      // T6: ring exhaustion and release
      load_n(32);
      chk("t6_load_rdy", int'(load_rdy), 0);
      chk("t6_free", int'(free_slot_nb), 0);
      load_vld = 1'b1; tick(); load_vld = 1'b0;
      chk("t6_free_still", int'(free_slot_nb), 0);
      chk("t6_pid_still", int'(load_pid), 2);
      do_done();
      chk("t6_load_rdy_back", int'(load_rdy), 1);
      chk("t6_free_back", int'(free_slot_nb), 12);
      wait_cmd("t6b", 14, 12);
      do_done();
      flush_pulse();
      wait_cmd("t6c", 26, 8);
      do_done();
      repeat (2) tick();

      // T7: unexpected completion is sticky and harmless
      batch_done = 1'b1; tick(); batch_done = 1'b0;
      chk("t7_err", int'(err_done_unexp), 1);
      chk("t7_free", int'(free_slot_nb), 32);
      chk("t7_inflight", int'(inflight_nb), 0);
      repeat (3) tick();
      chk("t7_err_sticky", int'(err_done_unexp), 1);

      // Reset mid-operation discards everything
      load_n(3);
      a_rst_n = 1'b0;
      #2;
      chk("rst_err", int'(err_done_unexp), 0);
      chk("rst_free", int'(free_slot_nb), 32);
      chk("rst_load_pid", int'(load_pid), 0);
      chk("rst_vld", int'(batch_cmd_vld), 0);
      tick();
      a_rst_n = 1'b1;
      tick();
      load_n(12);
      wait_cmd("rst_fresh", 0, 12);
      do_done();

`ifdef PEP_BATCH_TIMEOUT_EN
      begin
         int k;
         load_n(5);
         k = 0;
         while (!batch_cmd_vld && k < 200) begin tick(); k++; end
         chk("t3_to_cycles", k, TOC + 1);
         chk("t3_to_pid", int'(batch_cmd_pid), 12);
         chk("t3_to_nb", int'(batch_cmd_pbs_nb), 5);
         do_done();
      end
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
